// File: rtl/shf_pkg.sv
// Shared definitions for the shifter issue/writeback controller: class codes,
// default widths and the writeback-stage state encoding.
package shf_pkg;

  localparam int DATASIZE_D = 16;
  localparam int ADDRSIZE_D = 4;
  localparam int CNTSIZE_D  = 16;

  localparam logic [1:0] SHF_ASH = 2'b00;
  localparam logic [1:0] SHF_ROT = 2'b01;
  localparam logic [1:0] SHF_LZC = 2'b10;
  localparam logic [1:0] SHF_LOC = 2'b11;

  // The state bit is the writeback-stage valid bit.
  typedef enum logic {
    WB_IDLE = 1'b0,
    WB_BUSY = 1'b1
  } wb_state_e;

  // Leading-zero/one counts take a single operand, so Ry is not read.
  function automatic logic uses_ry(input logic [1:0] cls);
    return ~cls[1];
  endfunction

endpackage

// File: rtl/shf_hazard_chk.sv
// RAW check of the issuing instruction's sources against the pending writeback;
// the crossbar read is combinational, so a same-cycle read would return stale data.
module shf_hazard_chk
  import shf_pkg::*;
#(
  parameter int ADDRSIZE = ADDRSIZE_D
) (
  input  logic                wb_vld,
  input  logic [ADDRSIZE-1:0] wb_rn,
  input  logic [1:0]          cls,
  input  logic [ADDRSIZE-1:0] rx,
  input  logic [ADDRSIZE-1:0] ry,
  output logic                hazard
);

  assign hazard = wb_vld & ((rx == wb_rn) | (uses_ry(cls) & (ry == wb_rn)));

endmodule

// File: rtl/shf_issue_ctl.sv
// Shifter issue and writeback controller: issues decoded shift ops, drives the
// crossbar read/write addresses and retires SZ/SV into status and sticky bits.
module shf_issue_ctl
  import shf_pkg::*;
#(
  parameter int DATASIZE = DATASIZE_D,
  parameter int ADDRSIZE = ADDRSIZE_D,
  parameter int CNTSIZE  = CNTSIZE_D
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ins_vld,
  output logic                ins_rdy,
  input  logic [1:0]          ins_cls,
  input  logic [ADDRSIZE-1:0] ins_rn,
  input  logic [ADDRSIZE-1:0] ins_rx,
  input  logic [ADDRSIZE-1:0] ins_ry,
  input  logic                ps_hold,
  output logic                ps_shf_en,
  output logic [1:0]          ps_shf_cls,
  output logic [ADDRSIZE-1:0] ps_xb_raddx,
  output logic [ADDRSIZE-1:0] ps_xb_raddy,
  output logic                ps_xb_wen,
  output logic [ADDRSIZE-1:0] ps_xb_wadd,
  input  logic                shf_ps_sz,
  input  logic                shf_ps_sv,
  output logic                astat_sz,
  output logic                astat_sv,
  output logic                stky_sv,
  input  logic                stky_clr,
  output logic [CNTSIZE-1:0]  ret_cnt,
  output logic                busy
);

  // Data width only matters for pairing with the shifter; reject nonsense values.
  if (DATASIZE < 1) begin : g_dw_chk
    $error("shf_issue_ctl: DATASIZE must be positive");
  end

  wb_state_e           state;
  logic                wb_vld;
  logic [ADDRSIZE-1:0] wb_rn;
  logic                hazard;
  logic                fire;

  assign wb_vld = (state == WB_BUSY);

  shf_hazard_chk #(.ADDRSIZE(ADDRSIZE)) u_hazard (
    .wb_vld (wb_vld),
    .wb_rn  (wb_rn),
    .cls    (ins_cls),
    .rx     (ins_rx),
    .ry     (ins_ry),
    .hazard (hazard)
  );

  assign ins_rdy     = ~ps_hold & ~hazard;
  assign fire        = ins_vld & ins_rdy;
  assign ps_shf_en   = fire;
  assign ps_shf_cls  = ins_cls;
  assign ps_xb_raddx = ins_rx;
  assign ps_xb_raddy = ins_ry;

  assign ps_xb_wen   = wb_vld;
  assign ps_xb_wadd  = wb_rn;
  assign busy        = wb_vld;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= WB_IDLE;
      wb_rn    <= '0;
      astat_sz <= 1'b0;
      astat_sv <= 1'b0;
      stky_sv  <= 1'b0;
      ret_cnt  <= '0;
    end else begin
      state <= fire ? WB_BUSY : WB_IDLE;
      if (fire) wb_rn <= ins_rn;
      if (wb_vld) begin
        astat_sz <= shf_ps_sz;
        astat_sv <= shf_ps_sv;
        ret_cnt  <= ret_cnt + 1'b1;
      end
      // A new overflow in the clear cycle survives the clear.
      stky_sv <= (stky_sv & ~stky_clr) | (wb_vld & shf_ps_sv);
    end
  end

endmodule

// File: tb/tb_shf_issue_ctl.sv
// Directed bench for shf_issue_ctl with a retire scoreboard and a flag model.
module tb_shf_issue_ctl;

  logic        clk = 1'b0;
  logic        rst;
  logic        ins_vld;
  logic        ins_rdy;
  logic [1:0]  ins_cls;
  logic [3:0]  ins_rn, ins_rx, ins_ry;
  logic        ps_hold;
  logic        ps_shf_en;
  logic [1:0]  ps_shf_cls;
  logic [3:0]  ps_xb_raddx, ps_xb_raddy;
  logic        ps_xb_wen;
  logic [3:0]  ps_xb_wadd;
  logic        shf_ps_sz, shf_ps_sv;
  logic        astat_sz, astat_sv, stky_sv;
  logic        stky_clr;
  logic [15:0] ret_cnt;
  logic        busy;

  shf_issue_ctl #(.DATASIZE(16), .ADDRSIZE(4), .CNTSIZE(16)) dut (
    .clk(clk), .rst(rst),
    .ins_vld(ins_vld), .ins_rdy(ins_rdy), .ins_cls(ins_cls),
    .ins_rn(ins_rn), .ins_rx(ins_rx), .ins_ry(ins_ry),
    .ps_hold(ps_hold), .ps_shf_en(ps_shf_en), .ps_shf_cls(ps_shf_cls),
    .ps_xb_raddx(ps_xb_raddx), .ps_xb_raddy(ps_xb_raddy),
    .ps_xb_wen(ps_xb_wen), .ps_xb_wadd(ps_xb_wadd),
    .shf_ps_sz(shf_ps_sz), .shf_ps_sv(shf_ps_sv),
    .astat_sz(astat_sz), .astat_sv(astat_sv), .stky_sv(stky_sv),
    .stky_clr(stky_clr), .ret_cnt(ret_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] rn;
    logic       sz;
    logic       sv;
  } exp_t;

  exp_t sbq[$];
  int   n_vec = 0;
  int   n_err = 0;

  logic        m_sz, m_sv, m_stky;
  logic [15:0] m_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Retire-side monitor: checks status against the model, pops the scoreboard
  // on each write and plays the shifter by presenting that op's flags.
  always @(negedge clk) begin
    if (rst) begin
      sbq.delete();
      m_sz = 0; m_sv = 0; m_stky = 0; m_cnt = 0;
      chk("rst_wen", ps_xb_wen, 0);
    end else begin
      chk("astat_sz", astat_sz, m_sz);
      chk("astat_sv", astat_sv, m_sv);
      chk("stky_sv", stky_sv, m_stky);
      chk("ret_cnt", ret_cnt, m_cnt);
      chk("busy_eq_wen", busy, ps_xb_wen);
      if (ps_xb_wen) begin
        if (sbq.size() == 0) begin
          chk("wen_unexpected", ps_xb_wen, 0);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("wadd", ps_xb_wadd, e.rn);
          shf_ps_sz = e.sz;
          shf_ps_sv = e.sv;
          m_sz = e.sz;
          m_sv = e.sv;
          m_cnt = m_cnt + 16'd1;
          m_stky = (m_stky & ~stky_clr) | e.sv;
        end
      end else begin
        // Garbage flags outside writeback must not reach status.
        shf_ps_sz = 1'($urandom_range(1));
        shf_ps_sv = 1'($urandom_range(1));
        m_stky = m_stky & ~stky_clr;
      end
    end
  end

  task automatic drive(input logic vld, input logic [1:0] cls,
                       input logic [3:0] rn, input logic [3:0] rx, input logic [3:0] ry);
    @(posedge clk);
    #1;
    ins_vld = vld; ins_cls = cls; ins_rn = rn; ins_rx = rx; ins_ry = ry;
    ps_hold = 0; stky_clr = 0;
  endtask

  task automatic idle();
    drive(0, 2'b00, 4'd0, 4'd15, 4'd15);
  endtask

  task automatic issue(input logic [1:0] cls, input logic [3:0] rn, input logic [3:0] rx,
                       input logic [3:0] ry, input logic sz, input logic sv,
                       input logic hold, input logic exp_rdy);
    exp_t e;
    drive(1, cls, rn, rx, ry);
    ps_hold = hold;
    #1;
    chk("ins_rdy", ins_rdy, exp_rdy);
    chk("shf_en", ps_shf_en, exp_rdy);
    chk("shf_cls", ps_shf_cls, cls);
    chk("raddx", ps_xb_raddx, rx);
    chk("raddy", ps_xb_raddy, ry);
    if (exp_rdy) begin
      e.rn = rn; e.sz = sz; e.sv = sv;
      sbq.push_back(e);
    end
  endtask

  initial begin
    rst = 1; ins_vld = 0; ins_cls = 0; ins_rn = 0; ins_rx = 0; ins_ry = 0;
    ps_hold = 0; stky_clr = 0; shf_ps_sz = 0; shf_ps_sv = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_shf_en", ps_shf_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_astat", {astat_sz, astat_sv, stky_sv}, 3'b000);
    chk("rst_cnt", ret_cnt, 0);
    rst = 0;
    idle();

    // Single op: issue, write next cycle, status the cycle after
    issue(2'b00, 4'd3, 4'd1, 4'd2, 1'b0, 1'b1, 1'b0, 1'b1);
    idle(); #1;
    chk("single_wen", ps_xb_wen, 1);
    chk("single_wadd", ps_xb_wadd, 3);
    chk("single_en_off", ps_shf_en, 0);
    idle(); #1;
    chk("single_astat_sv", astat_sv, 1);
    chk("single_stky", stky_sv, 1);
    chk("single_cnt", ret_cnt, 1);
    chk("single_wen_off", ps_xb_wen, 0);

    // RAW on Rx: one stall cycle
    issue(2'b00, 4'd3, 4'd1, 4'd2, 1'b1, 1'b0, 1'b0, 1'b1);
    issue(2'b00, 4'd4, 4'd3, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0);
    issue(2'b00, 4'd4, 4'd3, 4'd5, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(); idle();
    // Leading-zero count ignores Ry: no stall
    issue(2'b00, 4'd3, 4'd1, 4'd2, 1'b0, 1'b0, 1'b0, 1'b1);
    issue(2'b10, 4'd7, 4'd4, 4'd3, 1'b1, 1'b1, 1'b0, 1'b1);
    idle(); idle();
    // Rotate reads Ry: stall
    issue(2'b00, 4'd6, 4'd1, 4'd2, 1'b0, 1'b1, 1'b0, 1'b1);
    issue(2'b01, 4'd9, 4'd7, 4'd6, 1'b0, 1'b0, 1'b0, 1'b0);
    issue(2'b01, 4'd9, 4'd7, 4'd6, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(); idle();

    // Streaming with one hold cycle
    issue(2'b00, 4'd8,  4'd0, 4'd1, 1'b1, 1'b0, 1'b0, 1'b1);
    issue(2'b01, 4'd9,  4'd0, 4'd1, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("hold_keeps_wb", ps_xb_wen, 1);
    issue(2'b01, 4'd9,  4'd0, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1);
    issue(2'b10, 4'd10, 4'd0, 4'd1, 1'b1, 1'b1, 1'b0, 1'b1);
    issue(2'b11, 4'd11, 4'd0, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(); idle();

    // Sticky: clear, then set and clear together, then clear alone
    idle(); stky_clr = 1;
    idle(); #1;
    chk("stky_cleared", stky_sv, 0);
    issue(2'b00, 4'd12, 4'd0, 4'd1, 1'b0, 1'b1, 1'b0, 1'b1);
    idle(); stky_clr = 1;
    idle(); stky_clr = 1; #1;
    chk("stky_set_wins", stky_sv, 1);
    idle(); #1;
    chk("stky_clr_alone", stky_sv, 0);

    // Reset in the writeback cycle drops the write
    issue(2'b00, 4'd5, 4'd1, 4'd2, 1'b1, 1'b1, 1'b0, 1'b1);
    idle(); #1;
    chk("mid_wen", ps_xb_wen, 1);
    chk("mid_wadd", ps_xb_wadd, 5);
    rst = 1; #1;
    chk("mid_wen_drop", ps_xb_wen, 0);
    chk("mid_busy_drop", busy, 0);
    idle(); rst = 0;
    idle(); #1;
    chk("post_rst_flags", {astat_sz, astat_sv, stky_sv}, 3'b000);
    chk("post_rst_cnt", ret_cnt, 0);

    // Counter wrap
    @(posedge clk); #1;
    force dut.ret_cnt = 16'hFFFF;
    m_cnt = 16'hFFFF;
    #1 release dut.ret_cnt;
    issue(2'b00, 4'd2, 4'd0, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(); idle(); #1;
    chk("cnt_wrap", ret_cnt, 0);

    idle(); idle();
    chk("sb_drain", sbq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
